// File: rtl/wb_arbiter_2_pkg.sv
// rtl/wb_arbiter_2_pkg.sv - shared constants and types for the two-master Wishbone arbiter
package wb_arbiter_2_pkg;

    // Number of masters arbitrated by wb_arbiter_2.
    localparam int ARB_PORTS = 2;

    // Encoding of the ARB_TYPE_ROUND_ROBIN parameter.
    localparam int ARB_ROUND_ROBIN = 1;

    // One-hot grant vector, bit k = master k owns the slave.
    typedef logic [ARB_PORTS-1:0] grant_t;

endpackage

// File: rtl/wb_arbiter_2_arbiter.sv
// rtl/wb_arbiter_2_arbiter.sv - generic N-port request-blocking arbiter with one-hot grant
//
// Purpose: registered one-hot grant. A grant is held for as long as its request
// stays high (no preemption). When the bus is released, the winner is chosen
// by fixed priority or round robin; the LSB option picks which end of the
// request vector wins ties.
//
// Ports:
//   clk    in   1       clock, all state on rising edge
//   rst    in   1       synchronous active-high reset
//   req    in   PORTS   request vector, bit k = port k wants the bus
//   grant  out  PORTS   registered one-hot grant, all zero when idle
module wb_arbiter_2_arbiter
    import wb_arbiter_2_pkg::*;
#(
    parameter int PORTS                 = 2,
    parameter int ARB_TYPE_ROUND_ROBIN  = 0,
    parameter int ARB_LSB_HIGH_PRIORITY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] req,
    output logic [PORTS-1:0] grant
);

    logic [PORTS-1:0] last_grant;
    logic [PORTS-1:0] rr_mask;
    logic [PORTS-1:0] cand;
    logic [PORTS-1:0] winner;
    logic             seen;
    logic             found;
    logic             hold;

    always_comb begin
        // rr_mask marks the ports that come after the last winner in the
        // priority order; they get first chance on the next arbitration.
        rr_mask = '0;
        seen    = 1'b0;
        if (ARB_LSB_HIGH_PRIORITY != 0) begin
            for (int i = 0; i < PORTS; i++) begin
                rr_mask[i] = seen;
                if (last_grant[i]) seen = 1'b1;
            end
        end else begin
            for (int i = PORTS - 1; i >= 0; i--) begin
                rr_mask[i] = seen;
                if (last_grant[i]) seen = 1'b1;
            end
        end

        // With no history, or nobody after the last winner requesting,
        // fall back to the plain priority order.
        cand = req;
        if (ARB_TYPE_ROUND_ROBIN == ARB_ROUND_ROBIN && last_grant != '0
                && (req & rr_mask) != '0) begin
            cand = req & rr_mask;
        end

        winner = '0;
        found  = 1'b0;
        if (ARB_LSB_HIGH_PRIORITY != 0) begin
            for (int i = 0; i < PORTS; i++) begin
                if (cand[i] && !found) begin
                    winner[i] = 1'b1;
                    found     = 1'b1;
                end
            end
        end else begin
            for (int i = PORTS - 1; i >= 0; i--) begin
                if (cand[i] && !found) begin
                    winner[i] = 1'b1;
                    found     = 1'b1;
                end
            end
        end

        // Owner still requesting: the bus stays locked to it.
        hold = |(grant & req);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= '0;
            last_grant <= '0;
        end else if (!hold) begin
            grant <= winner;
            if (|req) last_grant <= winner;
        end
    end

endmodule

// File: rtl/wb_arbiter_2.sv
// rtl/wb_arbiter_2.sv - two-master, one-slave Wishbone classic bus arbiter
//
// Purpose: grants the shared slave to one master per CYC, muxes the owner's
// request onto the slave port and routes slave responses back to the owner only.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   wbmN_adr/dat/we/sel/stb/cyc_i  master N request (N = 0,1)
//   wbmN_dat/ack/err/rty_o         response to master N
//   wbs_adr/dat/we/sel/stb/cyc_o   request to the slave
//   wbs_dat/ack/err/rty_i          slave response
module wb_arbiter_2
    import wb_arbiter_2_pkg::*;
#(
    parameter int DATA_WIDTH            = 32,
    parameter int ADDR_WIDTH            = 32,
    parameter int SELECT_WIDTH          = DATA_WIDTH / 8,
    parameter int ARB_TYPE_ROUND_ROBIN  = 0,
    parameter int ARB_LSB_HIGH_PRIORITY = 1
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
    input  logic                    wbm0_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
    input  logic                    wbm0_stb_i,
    output logic                    wbm0_ack_o,
    output logic                    wbm0_err_o,
    output logic                    wbm0_rty_o,
    input  logic                    wbm0_cyc_i,

    input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
    input  logic                    wbm1_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
    input  logic                    wbm1_stb_i,
    output logic                    wbm1_ack_o,
    output logic                    wbm1_err_o,
    output logic                    wbm1_rty_o,
    input  logic                    wbm1_cyc_i,

    output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    output logic                    wbs_we_o,
    output logic [SELECT_WIDTH-1:0] wbs_sel_o,
    output logic                    wbs_stb_o,
    input  logic                    wbs_ack_i,
    input  logic                    wbs_err_i,
    input  logic                    wbs_rty_i,
    output logic                    wbs_cyc_o
);

    grant_t grant;

    wb_arbiter_2_arbiter #(
        .PORTS                 (ARB_PORTS),
        .ARB_TYPE_ROUND_ROBIN  (ARB_TYPE_ROUND_ROBIN),
        .ARB_LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
    ) u_arbiter (
        .clk   (clk),
        .rst   (rst),
        .req   ({wbm1_cyc_i, wbm0_cyc_i}),
        .grant (grant)
    );

    // CYC/STB are gated by the live master inputs so the slave sees the
    // owner release the bus in the same cycle it drops CYC.
    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_we_o  = 1'b0;
        wbs_sel_o = '0;
        wbs_stb_o = 1'b0;
        wbs_cyc_o = 1'b0;
        if (grant[0]) begin
            wbs_adr_o = wbm0_adr_i;
            wbs_dat_o = wbm0_dat_i;
            wbs_we_o  = wbm0_we_i;
            wbs_sel_o = wbm0_sel_i;
            wbs_stb_o = wbm0_stb_i;
            wbs_cyc_o = wbm0_cyc_i;
        end else if (grant[1]) begin
            wbs_adr_o = wbm1_adr_i;
            wbs_dat_o = wbm1_dat_i;
            wbs_we_o  = wbm1_we_i;
            wbs_sel_o = wbm1_sel_i;
            wbs_stb_o = wbm1_stb_i;
            wbs_cyc_o = wbm1_cyc_i;
        end
    end

    assign wbm0_dat_o = wbs_dat_i;
    assign wbm1_dat_o = wbs_dat_i;

    assign wbm0_ack_o = wbs_ack_i & grant[0];
    assign wbm0_err_o = wbs_err_i & grant[0];
    assign wbm0_rty_o = wbs_rty_i & grant[0];
    assign wbm1_ack_o = wbs_ack_i & grant[1];
    assign wbm1_err_o = wbs_err_i & grant[1];
    assign wbm1_rty_o = wbs_rty_i & grant[1];

endmodule

// File: tb/tb_wb_arbiter_2.sv
// tb/tb_wb_arbiter_2.sv - self-checking bench for wb_arbiter_2 (fixed-priority and round-robin instances)
module tb_wb_arbiter_2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc;
    logic        s_ack, s_err, s_rty;

    logic [31:0] f_adr, f_dato, f_m0dat, f_m1dat;
    logic [3:0]  f_sel;
    logic        f_we, f_stb, f_cyc, f_m0ack, f_m0err, f_m0rty, f_m1ack, f_m1err, f_m1rty;
    logic [31:0] r_adr, r_dato, r_m0dat, r_m1dat;
    logic [3:0]  r_sel;
    logic        r_we, r_stb, r_cyc, r_m0ack, r_m0err, r_m0rty, r_m1ack, r_m1err, r_m1rty;

    logic [140:0] f_bus, r_bus;
    assign f_bus = {f_adr, f_dato, f_we, f_sel, f_stb, f_cyc,
                    f_m0dat, f_m0ack, f_m0err, f_m0rty, f_m1dat, f_m1ack, f_m1err, f_m1rty};
    assign r_bus = {r_adr, r_dato, r_we, r_sel, r_stb, r_cyc,
                    r_m0dat, r_m0ack, r_m0err, r_m0rty, r_m1dat, r_m1ack, r_m1err, r_m1rty};

    int total = 0;
    int bad   = 0;
    int of    = -1;   // model owner, fixed-priority instance (-1 = none)
    int orr   = -1;   // model owner, round-robin instance
    int lastr = -1;   // last master granted by the round-robin instance

    always #5 clk = ~clk;

    wb_arbiter_2 #(.ARB_TYPE_ROUND_ROBIN(0), .ARB_LSB_HIGH_PRIORITY(1)) dut_f (
        .clk(clk), .rst(rst),
        .wbm0_adr_i(m0_adr), .wbm0_dat_i(m0_dat), .wbm0_dat_o(f_m0dat), .wbm0_we_i(m0_we),
        .wbm0_sel_i(m0_sel), .wbm0_stb_i(m0_stb), .wbm0_ack_o(f_m0ack), .wbm0_err_o(f_m0err),
        .wbm0_rty_o(f_m0rty), .wbm0_cyc_i(m0_cyc),
        .wbm1_adr_i(m1_adr), .wbm1_dat_i(m1_dat), .wbm1_dat_o(f_m1dat), .wbm1_we_i(m1_we),
        .wbm1_sel_i(m1_sel), .wbm1_stb_i(m1_stb), .wbm1_ack_o(f_m1ack), .wbm1_err_o(f_m1err),
        .wbm1_rty_o(f_m1rty), .wbm1_cyc_i(m1_cyc),
        .wbs_adr_o(f_adr), .wbs_dat_i(s_dat), .wbs_dat_o(f_dato), .wbs_we_o(f_we),
        .wbs_sel_o(f_sel), .wbs_stb_o(f_stb), .wbs_ack_i(s_ack), .wbs_err_i(s_err),
        .wbs_rty_i(s_rty), .wbs_cyc_o(f_cyc)
    );

    wb_arbiter_2 #(.ARB_TYPE_ROUND_ROBIN(1), .ARB_LSB_HIGH_PRIORITY(1)) dut_r (
        .clk(clk), .rst(rst),
        .wbm0_adr_i(m0_adr), .wbm0_dat_i(m0_dat), .wbm0_dat_o(r_m0dat), .wbm0_we_i(m0_we),
        .wbm0_sel_i(m0_sel), .wbm0_stb_i(m0_stb), .wbm0_ack_o(r_m0ack), .wbm0_err_o(r_m0err),
        .wbm0_rty_o(r_m0rty), .wbm0_cyc_i(m0_cyc),
        .wbm1_adr_i(m1_adr), .wbm1_dat_i(m1_dat), .wbm1_dat_o(r_m1dat), .wbm1_we_i(m1_we),
        .wbm1_sel_i(m1_sel), .wbm1_stb_i(m1_stb), .wbm1_ack_o(r_m1ack), .wbm1_err_o(r_m1err),
        .wbm1_rty_o(r_m1rty), .wbm1_cyc_i(m1_cyc),
        .wbs_adr_o(r_adr), .wbs_dat_i(s_dat), .wbs_dat_o(r_dato), .wbs_we_o(r_we),
        .wbs_sel_o(r_sel), .wbs_stb_o(r_stb), .wbs_ack_i(s_ack), .wbs_err_i(s_err),
        .wbs_rty_i(s_rty), .wbs_cyc_o(r_cyc)
    );

    // Reference: who owns the bus after the next edge, from the arbitration rules.
    function automatic int model_next(int o, logic [1:0] req, bit rr, int last);
        if (o >= 0 && req[o]) return o;
        if (req == 2'b11) return (rr && last >= 0) ? 1 - last : 0;
        if (req[0]) return 0;
        if (req[1]) return 1;
        return -1;
    endfunction

    // Reference: everything the DUT should present given the owner and current inputs.
    function automatic logic [140:0] exp_bus(int o);
        logic [31:0] a, d;
        logic [3:0]  s;
        logic        we, stb, cyc;
        logic [2:0]  r0, r1;
        a = '0; d = '0; s = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0; r0 = '0; r1 = '0;
        if (o == 0) begin
            a = m0_adr; d = m0_dat; s = m0_sel; we = m0_we; stb = m0_stb; cyc = m0_cyc;
            r0 = {s_ack, s_err, s_rty};
        end else if (o == 1) begin
            a = m1_adr; d = m1_dat; s = m1_sel; we = m1_we; stb = m1_stb; cyc = m1_cyc;
            r1 = {s_ack, s_err, s_rty};
        end
        return {a, d, we, s, stb, cyc, s_dat, r0, s_dat, r1};
    endfunction

    task automatic tick();
        logic [1:0] req;
        logic       r;
        int         nf, nr;
        req = {m1_cyc, m0_cyc};
        r   = rst;
        nf  = model_next(of, req, 1'b0, -1);
        nr  = model_next(orr, req, 1'b1, lastr);
        @(posedge clk);
        #1;
        if (r) begin
            of = -1; orr = -1; lastr = -1;
        end else begin
            of = nf; orr = nr;
            if (nr >= 0) lastr = nr;
        end
    endtask

    task automatic idle();
        m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 1'b0; m0_stb = 1'b0; m0_cyc = 1'b0;
        m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 1'b0; m1_stb = 1'b0; m1_cyc = 1'b0;
        s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = $urandom; m1_cyc = 1'b1; m1_stb = 1'b1;
        s_ack = 1'b1; s_dat = $urandom;
        tick(); tick();
        #1;
        total++;
        if (f_bus !== exp_bus(-1)) begin bad++; $display("FAIL reset_fixed got=%h exp=%h", f_bus, exp_bus(-1)); end
        total++;
        if (r_bus !== exp_bus(-1)) begin bad++; $display("FAIL reset_rr got=%h exp=%h", r_bus, exp_bus(-1)); end
        total++;
        if ({f_cyc, f_stb, f_adr, f_m0ack, f_m1ack} !== 35'd0) begin
            bad++; $display("FAIL reset_idle got cyc=%b stb=%b adr=%h ack=%b%b exp all 0", f_cyc, f_stb, f_adr, f_m0ack, f_m1ack);
        end
        rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_single_m0();
        idle();
        m0_adr = 32'h1000; m0_dat = 32'h11223344; m0_sel = 4'hF; m0_we = 1'b1; m0_stb = 1'b1; m0_cyc = 1'b1;
        #1;
        total++;
        if (f_cyc !== 1'b0) begin bad++; $display("FAIL m0_latency got cyc=%b exp=0", f_cyc); end
        tick();
        #1;
        total++;
        if ({f_adr, f_dato, f_sel, f_we, f_cyc, f_stb} !== {32'h1000, 32'h11223344, 4'hF, 3'b111}) begin
            bad++; $display("FAIL m0_write_fields got adr=%h dat=%h sel=%h we=%b cyc=%b stb=%b exp 1000/11223344/f/1/1/1",
                            f_adr, f_dato, f_sel, f_we, f_cyc, f_stb);
        end
        s_ack = 1'b1;
        #1;
        total++;
        if ({f_m0ack, f_m1ack} !== 2'b10) begin bad++; $display("FAIL m0_ack got m0=%b m1=%b exp 1 0", f_m0ack, f_m1ack); end
        total++;
        if (r_bus !== exp_bus(orr)) begin bad++; $display("FAIL m0_rr got=%h exp=%h", r_bus, exp_bus(orr)); end
        idle();
        tick();
    endtask

    task automatic test_m1_read();
        idle();
        m1_adr = 32'h2000; m1_sel = 4'hF; m1_stb = 1'b1; m1_cyc = 1'b1;
        tick();
        s_dat = 32'hDEADBEEF; s_ack = 1'b1;
        #1;
        total++;
        if ({f_m1ack, f_m0ack, f_m1dat, f_adr, f_we} !== {2'b10, 32'hDEADBEEF, 32'h2000, 1'b0}) begin
            bad++; $display("FAIL m1_read got ack1=%b ack0=%b dat=%h adr=%h we=%b exp 1 0 deadbeef 2000 0",
                            f_m1ack, f_m0ack, f_m1dat, f_adr, f_we);
        end
        total++;
        if (r_bus !== exp_bus(orr)) begin bad++; $display("FAIL m1_read_rr got=%h exp=%h", r_bus, exp_bus(orr)); end
        idle();
        tick();
    endtask

    task automatic test_simultaneous();
        idle();
        m0_adr = 32'hA0; m0_cyc = 1'b1; m0_stb = 1'b1;
        m1_adr = 32'hB1; m1_cyc = 1'b1; m1_stb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (f_adr !== 32'hA0 || f_cyc !== 1'b1) begin
                bad++; $display("FAIL simul_m0_first cyc%0d got adr=%h cyc=%b exp a0 1", i, f_adr, f_cyc);
            end
        end
        m0_cyc = 1'b0; m0_stb = 1'b0;
        #1;
        total++;
        if (f_cyc !== 1'b0 || f_stb !== 1'b0) begin bad++; $display("FAIL simul_drop got cyc=%b stb=%b exp 0 0", f_cyc, f_stb); end
        tick();
        total++;
        if (f_adr !== 32'hB1 || f_cyc !== 1'b1) begin bad++; $display("FAIL simul_handover got adr=%h cyc=%b exp b1 1", f_adr, f_cyc); end
        idle();
        tick();
    endtask

    task automatic test_round_robin();
        logic [0:5] seq;
        int         e;
        idle();
        m0_adr = 32'hC0; m1_adr = 32'hC1;
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            e = k % 2;
            seq[k] = r_adr[0];
            total++;
            if (r_adr !== (e == 0 ? 32'hC0 : 32'hC1)) begin
                bad++; $display("FAIL rr_alternate step%0d got adr=%h exp owner %0d", k, r_adr, e);
            end
            // owner finishes its cycle: drops CYC for one edge, then asks again
            if (e == 0) begin m0_cyc = 1'b0; m0_stb = 1'b0; end
            else begin m1_cyc = 1'b0; m1_stb = 1'b0; end
            tick();
            m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
            #1;
        end
        total++;
        if (seq !== 6'b010101) begin bad++; $display("FAIL rr_sequence got %b exp 010101", seq); end
        idle();
        tick();
    endtask

    task automatic test_lock();
        idle();
        m0_adr = 32'hD0; m0_cyc = 1'b1;
        tick();
        m1_adr = 32'hD1; m1_cyc = 1'b1; m1_stb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m0_stb = 1'b1;
            s_ack = (i == 0); s_err = (i == 1); s_rty = (i == 2);
            tick();
            total++;
            if ({f_m1ack, f_m1err, f_m1rty, r_m1ack, r_m1err, r_m1rty} !== 6'b0 || f_adr !== 32'hD0
                    || {f_m0ack, f_m0err, f_m0rty} !== {s_ack, s_err, s_rty}) begin
                bad++; $display("FAIL lock_owner strobe%0d got adr=%h m0=%b%b%b m1=%b%b%b", i, f_adr,
                                f_m0ack, f_m0err, f_m0rty, f_m1ack, f_m1err, f_m1rty);
            end
            s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; m0_stb = 1'b0;
            tick();
        end
        m0_cyc = 1'b0;
        tick();
        total++;
        if (f_adr !== 32'hD1 || r_adr !== 32'hD1) begin bad++; $display("FAIL lock_release got f=%h r=%h exp d1", f_adr, r_adr); end
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        idle();
        m0_adr = 32'hE0; m0_cyc = 1'b1; m0_stb = 1'b1;
        tick();
        rst = 1'b1; s_ack = 1'b1;
        tick();
        total++;
        if ({f_cyc, f_m0ack, f_m1ack, r_cyc, r_m0ack} !== 5'b0) begin
            bad++; $display("FAIL reset_mid got fcyc=%b fack=%b%b rcyc=%b rack=%b exp 0", f_cyc, f_m0ack, f_m1ack, r_cyc, r_m0ack);
        end
        rst = 1'b0;
        tick();
        total++;
        if (f_cyc !== 1'b1 || f_m0ack !== 1'b1 || f_adr !== 32'hE0) begin
            bad++; $display("FAIL reset_resume got cyc=%b ack=%b adr=%h exp 1 1 e0", f_cyc, f_m0ack, f_adr);
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) m0_cyc = ~m0_cyc;
            if ($urandom_range(0, 3) == 0) m1_cyc = ~m1_cyc;
            m0_stb = m0_cyc & $urandom_range(0, 1); m1_stb = m1_cyc & $urandom_range(0, 1);
            m0_adr = $urandom; m0_dat = $urandom; m0_sel = 4'($urandom); m0_we = 1'($urandom);
            m1_adr = $urandom; m1_dat = $urandom; m1_sel = 4'($urandom); m1_we = 1'($urandom);
            s_dat = $urandom; s_ack = 1'($urandom); s_err = 1'($urandom); s_rty = 1'($urandom);
            #1;
            total++;
            if (f_bus !== exp_bus(of)) begin bad++; $display("FAIL random_fixed n=%0d got=%h exp=%h", n, f_bus, exp_bus(of)); end
            total++;
            if (r_bus !== exp_bus(orr)) begin bad++; $display("FAIL random_rr n=%0d got=%h exp=%h", n, r_bus, exp_bus(orr)); end
            tick();
        end
        rst = 1'b0;
        idle();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_single_m0();
        test_m1_read();
        test_simultaneous();
        test_round_robin();
        test_lock();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
